rnic_lite_req_arb: RTL and testbench

Round-robin arbiter that shares the single AXI-lite configuration transaction generator (`rnic_lite_txn_gen` request port: `i_gen_txns`/`i_addr`/`i_data`/`o_txns_done`) between NUM_REQ independent configuration requesters (QP setup, CQ/doorbell init, stats clear, and so on). It serialises write requests, holds the address and data stable for the generator's whole transaction, returns a per-requester completion pulse, and optionally bounds each transaction with a timeout. It stops granting once the test-completed phase begins, so the generator can run its final register reads undisturbed.

---
 rtl/rnic_lite_req_arb.sv | 184 ++++++++++++++++++
 tb/tb_rnic_lite_req_arb.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rnic_lite_req_arb.sv
// Round-robin arbiter sharing one AXI-lite transaction generator between NUM_REQ requesters.
// Optional per-transaction timeout with ORPHAN recovery: define RNIC_LITE_ARB_TIMEOUT_EN.
module rnic_lite_req_arb #(
    parameter int NUM_REQ                 = 4,
    parameter int C_S_AXI_LITE_ADDR_WIDTH = 32,
    parameter int C_S_AXI_LITE_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES          = 4096
) (
    input  logic                                       s_axi_lite_aclk,
    input  logic                                       s_axi_lite_rst,
    input  logic [NUM_REQ-1:0]                         i_req,
    input  logic [NUM_REQ*C_S_AXI_LITE_ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*C_S_AXI_LITE_DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]                         o_req_done,
    output logic [NUM_REQ-1:0]                         o_req_err,
    output logic                                       o_gen_txns,
    output logic [C_S_AXI_LITE_ADDR_WIDTH-1:0]         o_addr,
    output logic [C_S_AXI_LITE_DATA_WIDTH-1:0]         o_data,
    input  logic                                       i_txns_done,
    input  logic                                       i_test_completed,
    output logic                                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0]                 o_grant_id
);
    localparam int AW  = C_S_AXI_LITE_ADDR_WIDTH;
    localparam int DW  = C_S_AXI_LITE_DATA_WIDTH;
    localparam int IDW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_ORPHAN = 2'd2} state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = {NUM_REQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d, gid_q, gid_d, win_idx_s, next_ptr_s;
    logic [NUM_REQ-1:0] mask_q, mask_d, done_q, done_d, err_q, err_d, avail_s;
    logic               gen_q, gen_d, busy_q, busy_d, win_found_s;
    logic [AW-1:0]      addr_q, addr_d, win_addr_s;
    logic [DW-1:0]      data_q, data_d, win_data_s;
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0]      cnt_q, cnt_d;
`else
    logic               unused_cfg_s;
    assign unused_cfg_s = (TIMEOUT_CYCLES > 1);
`endif

    // Winner search: descending scan so the lowest offset from ptr is kept last.
    always_comb begin
        int             scan_idx;
        logic [IDW-1:0] cand;
        avail_s     = i_req & ~mask_q;
        win_found_s = 1'b0;
        win_idx_s   = {IDW{1'b0}};
        win_addr_s  = {AW{1'b0}};
        win_data_s  = {DW{1'b0}};
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_idx    = (int'(ptr_q) + i) % NUM_REQ;
            cand        = IDW'(scan_idx);
            win_found_s = avail_s[cand] ? 1'b1 : win_found_s;
            win_idx_s   = avail_s[cand] ? cand : win_idx_s;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx_s == IDW'(k)) begin
                win_addr_s = i_req_addr[k*AW +: AW];
                win_data_s = i_req_data[k*DW +: DW];
            end else begin
                win_addr_s = win_addr_s;
                win_data_s = win_data_s;
            end
        end
        next_ptr_s = (gid_q == IDW'(NUM_REQ - 1)) ? {IDW{1'b0}} : gid_q + IDW'(1'b1);
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        gid_d   = gid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gen_d   = 1'b0;
        done_d  = {NUM_REQ{1'b0}};
        err_d   = {NUM_REQ{1'b0}};
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mask_d = {NUM_REQ{1'b0}};
                if (!i_test_completed && win_found_s) begin
                    state_d = ST_WAIT;
                    gid_d   = win_idx_s;
                    addr_d  = win_addr_s;
                    data_d  = win_data_s;
                    gen_d   = 1'b1;
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
                    cnt_d   = {CW{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (i_txns_done) begin
                    state_d = ST_IDLE;
                    done_d  = onehot(gid_q);
                    ptr_d   = next_ptr_s;
                    mask_d  = onehot(gid_q);
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ORPHAN;
                    err_d   = onehot(gid_q);
                end else begin
                    cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1'b1);
`else
                end else begin
                    state_d = ST_WAIT;
`endif
                end
            end
            // The late completion of a timed-out transaction is swallowed here.
            ST_ORPHAN: begin
                if (i_txns_done) begin
                    state_d = ST_IDLE;
                    ptr_d   = next_ptr_s;
                    mask_d  = onehot(gid_q);
                end else begin
                    state_d = ST_ORPHAN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge s_axi_lite_aclk) begin
        if (s_axi_lite_rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= {IDW{1'b0}};
            mask_q  <= {NUM_REQ{1'b0}};
            gid_q   <= {IDW{1'b0}};
            addr_q  <= {AW{1'b0}};
            data_q  <= {DW{1'b0}};
            gen_q   <= 1'b0;
            done_q  <= {NUM_REQ{1'b0}};
            err_q   <= {NUM_REQ{1'b0}};
            busy_q  <= 1'b0;
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
            cnt_q   <= {CW{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            mask_q  <= mask_d;
            gid_q   <= gid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gen_q   <= gen_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
`ifdef RNIC_LITE_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign o_req_done = done_q;
    assign o_req_err  = err_q;
    assign o_gen_txns = gen_q;
    assign o_addr     = addr_q;
    assign o_data     = data_q;
    assign o_busy     = busy_q;
    assign o_grant_id = gid_q;

endmodule

// File: tb/tb_rnic_lite_req_arb.sv
// Self-checking bench for rnic_lite_req_arb: vector table plus hand-written corner sequences.
module tb_rnic_lite_req_arb;
    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TC = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    i_req;
    logic [NR*AW-1:0] i_req_addr;
    logic [NR*DW-1:0] i_req_data;
    logic [NR-1:0]    o_req_done, o_req_err;
    logic             o_gen_txns, i_txns_done, i_test_completed, o_busy;
    logic [AW-1:0]    o_addr;
    logic [DW-1:0]    o_data;
    logic [1:0]       o_grant_id;

    logic [AW-1:0] addr_tab [NR];
    logic [DW-1:0] data_tab [NR];

    typedef struct {
        logic [3:0] req;
        logic [3:0] drop;
        int         lat;
        logic [1:0] gid;
    } vec_t;
    vec_t tbl [9];

    typedef struct packed {
        logic [1:0]    gid;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rnic_lite_req_arb #(
        .NUM_REQ(NR), .C_S_AXI_LITE_ADDR_WIDTH(AW),
        .C_S_AXI_LITE_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)
    ) dut (
        .s_axi_lite_aclk(clk), .s_axi_lite_rst(rst),
        .i_req(i_req), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_req_done(o_req_done), .o_req_err(o_req_err), .o_gen_txns(o_gen_txns),
        .o_addr(o_addr), .o_data(o_data), .i_txns_done(i_txns_done),
        .i_test_completed(i_test_completed), .o_busy(o_busy), .o_grant_id(o_grant_id)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic no_grant(input int n);
        repeat (n) begin
            tick();
            chk("no_grant", {63'd0, o_gen_txns}, 64'd0);
        end
    endtask

    // Push the expected grant, wait (bounded) for the start pulse, pop and compare.
    task automatic start_txn(input logic [1:0] gid, input int exp_lat);
        exp_t e;
        int   lat;
        e.gid  = gid;
        e.addr = addr_tab[gid];
        e.data = data_tab[gid];
        sb_q.push_back(e);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!o_gen_txns && lat < 40);
        chk("gen_seen", {63'd0, o_gen_txns}, 64'd1);
        if (exp_lat > 0) chk("grant_lat", 64'(lat), 64'(exp_lat));
        e = sb_q.pop_front();
        chk("grant_id", {62'd0, o_grant_id}, {62'd0, e.gid});
        chk("grant_addr", {32'd0, o_addr}, {32'd0, e.addr});
        chk("grant_data", {32'd0, o_data}, {32'd0, e.data});
        chk("busy_grant", {63'd0, o_busy}, 64'd1);
    endtask

    task automatic finish_txn(input logic [1:0] gid, input int lat, input logic [3:0] drop);
        logic [3:0] oh;
        oh = 4'b0001 << gid;
        repeat (lat) begin
            tick();
            chk("gen_single", {63'd0, o_gen_txns}, 64'd0);
        end
        chk("addr_hold", {32'd0, o_addr}, {32'd0, addr_tab[gid]});
        chk("data_hold", {32'd0, o_data}, {32'd0, data_tab[gid]});
        i_txns_done = 1'b1;
        tick();
        i_txns_done = 1'b0;
        chk("req_done", {60'd0, o_req_done}, {60'd0, oh});
        chk("no_err", {60'd0, o_req_err}, 64'd0);
        chk("idle_after", {63'd0, o_busy}, 64'd0);
        i_req = i_req & ~drop;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int r = 0; r < NR; r++) begin
            addr_tab[r] = 32'h5006_0000 + 32'(r * 16);
            data_tab[r] = 32'h0000_00A3 + 32'(r);
            i_req_addr[r*AW +: AW] = addr_tab[r];
            i_req_data[r*DW +: DW] = data_tab[r];
        end
        tbl[0] = '{4'b0100, 4'b0100, 5, 2'd2};
        tbl[1] = '{4'b0001, 4'b0001, 1, 2'd0};
        tbl[2] = '{4'b0010, 4'b0010, 0, 2'd1};
        tbl[3] = '{4'b1000, 4'b1000, 3, 2'd3};
        tbl[4] = '{4'b1111, 4'b0000, 3, 2'd0};
        tbl[5] = '{4'b1111, 4'b0000, 3, 2'd1};
        tbl[6] = '{4'b1111, 4'b0000, 3, 2'd2};
        tbl[7] = '{4'b1111, 4'b0000, 3, 2'd3};
        tbl[8] = '{4'b1111, 4'b1111, 3, 2'd0};

        rst = 1'b1; i_req = 4'b0000; i_txns_done = 1'b0; i_test_completed = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_ctrl", {53'd0, o_gen_txns, o_req_done, o_req_err, o_busy, o_grant_id}, 64'd0);
        chk("rst_addr", {32'd0, o_addr}, 64'd0);
        chk("rst_data", {32'd0, o_data}, 64'd0);

        // Single requests, then round-robin over all four held high.
        for (int v = 0; v < 9; v++) begin
            i_req = tbl[v].req;
            start_txn(tbl[v].gid, 1);
            finish_txn(tbl[v].gid, tbl[v].lat, tbl[v].drop);
        end

        // Re-grant mask: requester 1 holds i_req through its done cycle.
        i_req = 4'b0010;
        start_txn(2'd1, 1);
        finish_txn(2'd1, 2, 4'b0000);
        tick();
        i_req = 4'b0000;
        no_grant(5);

        // test_completed raised during WAIT for 0 while 3 pends.
        i_req = 4'b0001;
        start_txn(2'd0, 1);
        tick();
        i_test_completed = 1'b1;
        i_req = 4'b1001;
        finish_txn(2'd0, 2, 4'b0001);
        no_grant(6);
        i_test_completed = 1'b0;
        start_txn(2'd3, 1);
        finish_txn(2'd3, 1, 4'b1000);

`ifdef RNIC_LITE_ARB_TIMEOUT_EN
        // Timeout: err exactly TC cycles after the start pulse.
        i_req = 4'b0100;
        start_txn(2'd2, 1);
        k = 0;
        do begin
            tick();
            k++;
        end while (o_req_err == 4'b0000 && k < 40);
        chk("err_lat", 64'(k), 64'(TC));
        chk("err_vec", {60'd0, o_req_err}, {60'd0, 4'b0100});
        chk("err_no_done", {60'd0, o_req_done}, 64'd0);
        i_req = 4'b0001;
        no_grant(4);
        chk("orphan_busy", {63'd0, o_busy}, 64'd1);
        i_txns_done = 1'b1;
        tick();
        i_txns_done = 1'b0;
        chk("orphan_no_done", {56'd0, o_req_done, o_req_err}, 64'd0);
        chk("orphan_idle", {63'd0, o_busy}, 64'd0);
        i_req = 4'b1001;
        start_txn(2'd3, 1);
        finish_txn(2'd3, 2, 4'b1000);
        // Done arriving in the very cycle the timeout would fire.
        start_txn(2'd0, 1);
        finish_txn(2'd0, TC - 1, 4'b0001);
`else
        i_req = 4'b0100;
        start_txn(2'd2, 1);
        k = 0;
        repeat (3 * TC) begin
            tick();
            if (o_req_err != 4'b0000 || !o_busy) k++;
        end
        chk("no_timeout", 64'(k), 64'd0);
        finish_txn(2'd2, 0, 4'b0100);
`endif

        // Reset mid-WAIT, then a stale completion.
        i_req = 4'b0010;
        start_txn(2'd1, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ctrl", {53'd0, o_gen_txns, o_req_done, o_req_err, o_busy, o_grant_id}, 64'd0);
        chk("mid_rst_addr", {32'd0, o_addr}, 64'd0);
        chk("mid_rst_data", {32'd0, o_data}, 64'd0);
        i_req = 4'b0000;
        i_txns_done = 1'b1;
        tick();
        i_txns_done = 1'b0;
        chk("stale_done", {59'd0, o_req_done, o_busy}, 64'd0);
        no_grant(3);
        i_req = 4'b1010;
        start_txn(2'd1, 1);
        finish_txn(2'd1, 1, 4'b1010);

        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
